ddr2_phy_mlane: RTL and testbench

DDR2_PHY_MLANE -- requirements
Module: ddr2_phy_mlane

---
 rtl/ddr2_phy_pkg.sv | 10 +
 rtl/ddr2_phy_lat_ctr.sv | 17 +
 rtl/ddr2_phy_mlane.sv | 117 +++++++++++
 tb/tb_ddr2_phy_mlane.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ddr2_phy_pkg.sv
// ddr2_phy_pkg: shared FSM states, NOP command and burst/latency limits for the DDR2 PHY
package ddr2_phy_pkg;
  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_PRE, WR_BURST, WR_POST, RD_WAIT, RD_BURST} state_t;
  localparam logic [3:0] NOP = 4'b1111;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int BL_SHORT = 4;
  localparam int BL_LONG = 8;
  localparam int CTR_W = $clog2(16);
endpackage

// File: rtl/ddr2_phy_lat_ctr.sv
// ddr2_phy_lat_ctr: loadable down-counter with a done flag for latency and beat counts
module ddr2_phy_lat_ctr
  import ddr2_phy_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CTR_W-1:0] val,
  output logic             done
);
  logic [CTR_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/ddr2_phy_mlane.sv
// ddr2_phy_mlane: multi-lane DDR2 PHY with command mux, write burst launch and read capture
module ddr2_phy_mlane
  import ddr2_phy_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int ADDR_W = 13,
  parameter int BA_W = 2,
  parameter int WL = 2,
  parameter int RL = 3,
  parameter int BL = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ready,
  input  logic [3:0]             init_cmd,
  input  logic [3:0]             prot_cmd,
  input  logic [BA_W-1:0]        init_ba,
  input  logic [BA_W-1:0]        prot_ba,
  input  logic [ADDR_W-1:0]      init_a,
  input  logic [ADDR_W-1:0]      prot_a,
  input  logic                   init_odt,
  input  logic                   prot_odt,
  input  logic                   init_cke,
  input  logic                   pm_cke_ovr,
  input  logic                   pm_cke_val,
  input  logic                   wr_start,
  input  logic [8*NUM_LANES-1:0] wr_data,
  input  logic [NUM_LANES-1:0]   wr_dm,
  output logic                   wr_data_ack,
  input  logic                   rd_start,
  output logic [8*NUM_LANES-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   rd_last,
  output logic                   busy,
  output logic                   collision,
  output logic                   ck_pad,
  output logic                   ckbar_pad,
  output logic                   cke_pad,
  output logic                   csbar_pad,
  output logic                   rasbar_pad,
  output logic                   casbar_pad,
  output logic                   webar_pad,
  output logic [BA_W-1:0]        ba_pad,
  output logic [ADDR_W-1:0]      a_pad,
  output logic [NUM_LANES-1:0]   dm_pad,
  output logic                   odt_pad,
  inout  wire  [8*NUM_LANES-1:0] dq_pad,
  inout  wire  [NUM_LANES-1:0]   dqs_pad,
  inout  wire  [NUM_LANES-1:0]   dqsbar_pad
);
  state_t state, next;
  logic done, load, drive, rd_beat;
  logic [CTR_W-1:0] val;
  logic [8*NUM_LANES-1:0] dq_q;
  logic [NUM_LANES-1:0] dqs_val;
  ddr2_phy_lat_ctr u_ctr (.clk(clk), .rst_n(rst_n), .load(load), .val(val), .done(done));
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = wr_start ? WR_WAIT : rd_start ? RD_WAIT : IDLE;
      WR_WAIT:  next = done ? WR_PRE : WR_WAIT;
      WR_PRE:   next = WR_BURST;
      WR_BURST: next = done ? WR_POST : WR_BURST;
      WR_POST:  next = IDLE;
      RD_WAIT:  next = done ? RD_BURST : RD_WAIT;
      RD_BURST: next = done ? IDLE : RD_BURST;
      default:  next = IDLE;
    endcase
    if (!ready && state != IDLE) next = IDLE;
    load = next != state;
    val = next == WR_WAIT ? CTR_W'(WL - 1) :
          next == RD_WAIT ? CTR_W'(RL - 1) :
          (next == WR_BURST || next == RD_BURST) ? CTR_W'(BL - 1) : '0;
  end
  assign busy = state != IDLE;
  assign drive = state == WR_PRE || state == WR_BURST || state == WR_POST;
  assign wr_data_ack = ready && (state == WR_PRE || (state == WR_BURST && !done));
  assign rd_beat = ready && state == RD_BURST;
  assign ckbar_pad = ~ck_pad;
  assign dqs_val = state == WR_BURST ? {NUM_LANES{~ck_pad}} : '0;
  // Tristates depend only on state, which resets asynchronously, so reset frees the bus at once
  assign dq_pad = drive ? dq_q : 'z;
  assign dqs_pad = drive ? dqs_val : 'z;
  assign dqsbar_pad = drive ? ~dqs_val : 'z;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ck_pad <= 1'b0;
      {csbar_pad, rasbar_pad, casbar_pad, webar_pad} <= NOP;
      cke_pad <= 1'b0;
      odt_pad <= 1'b0;
      ba_pad <= '0;
      a_pad <= '0;
      dm_pad <= '0;
      dq_q <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      collision <= 1'b0;
    end else begin
      state <= next;
      ck_pad <= ~ck_pad;
      {csbar_pad, rasbar_pad, casbar_pad, webar_pad} <= ready ? prot_cmd : init_cmd;
      cke_pad <= !ready ? init_cke : pm_cke_ovr ? pm_cke_val : 1'b1;
      odt_pad <= ready ? prot_odt : init_odt;
      ba_pad <= ready ? prot_ba : init_ba;
      a_pad <= ready ? prot_a : init_a;
      if (wr_data_ack) begin
        dq_q <= wr_data;
        dm_pad <= wr_dm;
      end
      if (rd_beat) rd_data <= dq_pad;
      rd_valid <= rd_beat;
      rd_last <= rd_beat && done;
      collision <= busy ? (wr_start || rd_start) : (wr_start && rd_start);
    end
endmodule

// File: tb/tb_ddr2_phy_mlane.sv
// tb_ddr2_phy_mlane: directed scoreboard bench for the DDR2 PHY command, write and read paths
module tb_ddr2_phy_mlane;
  logic clk = 0, rst_n = 0, ready = 0;
  logic [3:0] init_cmd = 4'b0010, prot_cmd = 4'b1111;
  logic [1:0] init_ba = 0, prot_ba = 0;
  logic [12:0] init_a = 0, prot_a = 0;
  logic init_odt = 0, prot_odt = 0, init_cke = 1, pm_cke_ovr = 0, pm_cke_val = 1;
  logic wr_start = 0, rd_start = 0;
  logic [15:0] wr_data = 0;
  logic [1:0] wr_dm = 0;
  logic wr_data_ack, rd_valid, rd_last, busy, collision;
  logic [15:0] rd_data;
  logic ck_pad, ckbar_pad, cke_pad, csbar_pad, rasbar_pad, casbar_pad, webar_pad, odt_pad;
  logic [1:0] ba_pad, dm_pad;
  logic [12:0] a_pad;
  wire [15:0] dq_pad;
  wire [1:0] dqs_pad, dqsbar_pad;
  logic tb_en = 1;
  logic [15:0] tb_dq = 16'h5A5A;
  localparam logic [15:0] PROBE = 16'h5A5A;
  assign dq_pad = tb_en ? tb_dq : 'z;
  assign dqs_pad = tb_en ? 2'b01 : 'z;
  assign dqsbar_pad = tb_en ? 2'b10 : 'z;
  logic [15:0] words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [1:0] dms [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [15:0] rwords [4] = '{16'hA5A5, 16'hB4B4, 16'hC3C3, 16'hD2D2};
  logic [16:0] rq[$];
  int checks = 0, failures = 0, wcnt = 0;
  ddr2_phy_mlane dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .init_cmd(init_cmd), .prot_cmd(prot_cmd),
    .init_ba(init_ba), .prot_ba(prot_ba), .init_a(init_a), .prot_a(prot_a),
    .init_odt(init_odt), .prot_odt(prot_odt), .init_cke(init_cke),
    .pm_cke_ovr(pm_cke_ovr), .pm_cke_val(pm_cke_val), .wr_start(wr_start),
    .wr_data(wr_data), .wr_dm(wr_dm), .wr_data_ack(wr_data_ack), .rd_start(rd_start),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy),
    .collision(collision), .ck_pad(ck_pad), .ckbar_pad(ckbar_pad), .cke_pad(cke_pad),
    .csbar_pad(csbar_pad), .rasbar_pad(rasbar_pad), .casbar_pad(casbar_pad),
    .webar_pad(webar_pad), .ba_pad(ba_pad), .a_pad(a_pad), .dm_pad(dm_pad),
    .odt_pad(odt_pad), .dq_pad(dq_pad), .dqs_pad(dqs_pad), .dqsbar_pad(dqsbar_pad)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [3:0] cmd();
    return {csbar_pad, rasbar_pad, casbar_pad, webar_pad};
  endfunction
  // Write data source: advances one word per acknowledged beat, rewinds while idle
  initial forever begin
    @(negedge clk);
    if (!busy) wcnt = 0;
    wr_data = words[wcnt % 4];
    wr_dm = dms[wcnt % 4];
    if (wr_data_ack) wcnt++;
  end
  // Read monitor: every rd_valid beat must match the next queued expectation
  initial forever begin
    @(negedge clk);
    if (rd_valid) begin
      if (rq.size() == 0) chk("rd_unexpected", {rd_last, rd_data}, 17'h0);
      else chk("rd_beat", {rd_last, rd_data}, rq.pop_front());
    end
  end
  task automatic do_write(input bit both);
    @(negedge clk); wr_start = 1; rd_start = both;
    @(negedge clk); wr_start = 0; rd_start = 0;
    chk("wr_busy", busy, 1);
    if (both) chk("coll_hi", collision, 1);
    @(negedge clk); tb_en = 0;
    chk("wr_wait_ack", wr_data_ack, 0);
    if (both) chk("coll_lo", collision, 0);
    @(negedge clk);
    chk("pre_ack", wr_data_ack, 1);
    chk("pre_dqs", {dqs_pad, dqsbar_pad}, 4'b0011);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("wr_dq", dq_pad, words[j]);
      chk("wr_dm", dm_pad, dms[j]);
      chk("wr_dqs", {dqs_pad, dqsbar_pad}, {~ck_pad, ~ck_pad, ck_pad, ck_pad});
      chk("wr_ack", wr_data_ack, j < 3);
    end
    @(negedge clk);
    chk("post_dqs", {dqs_pad, dqsbar_pad}, 4'b0011);
    chk("post_busy", busy, 1);
    @(negedge clk); tb_en = 1; #1;
    chk("wr_rel_dq", dq_pad, PROBE);
    chk("wr_rel_dqs", {dqs_pad, dqsbar_pad}, 4'b0110);
    chk("wr_idle", busy, 0);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_cmd", cmd(), 4'b1111);
    chk("rst_misc", {cke_pad, odt_pad, ck_pad, busy, rd_valid, rd_last, wr_data_ack, collision}, 0);
    chk("rst_addr", {a_pad, ba_pad, dm_pad, rd_data}, 0);
    chk("rst_dq", dq_pad, PROBE);
    rst_n = 1;
    @(negedge clk);
    chk("init_cmd", cmd(), 4'b0010);
    chk("init_cke", cke_pad, 1);
    chk("ck_tog", {ck_pad, ckbar_pad}, 2'b10);
    ready = 1; prot_cmd = 4'b0011; prot_a = 13'h123; prot_ba = 2; prot_odt = 1;
    pm_cke_ovr = 1; pm_cke_val = 0;
    @(negedge clk);
    chk("prot_cmd", cmd(), 4'b0011);
    chk("prot_addr", {odt_pad, ba_pad, a_pad}, {1'b1, 2'd2, 13'h123});
    chk("pm_cke0", cke_pad, 0);
    pm_cke_ovr = 0; prot_cmd = 4'b1111; prot_odt = 0;
    @(negedge clk);
    chk("pm_cke1", cke_pad, 1);
    do_write(0);
    @(negedge clk); rd_start = 1;
    for (int j = 0; j < 4; j++) rq.push_back({j == 3, rwords[j]});
    @(negedge clk); rd_start = 0;
    chk("rd_busy", busy, 1);
    repeat (3) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      tb_dq = rwords[j];
      @(negedge clk);
    end
    tb_dq = PROBE;
    @(negedge clk);
    chk("rd_done", {busy, rd_valid}, 0);
    chk("rd_drained", rq.size(), 0);
    do_write(1);
    repeat (2) @(negedge clk);
    chk("coll_no_rd", rq.size(), 0);
    rd_start = 1;
    @(negedge clk); rd_start = 0; ready = 0;
    @(negedge clk);
    chk("rdy_drop_idle", busy, 0);
    repeat (8) @(negedge clk);
    ready = 1;
    @(negedge clk); wr_start = 1;
    @(negedge clk); wr_start = 0;
    @(negedge clk); tb_en = 0;
    repeat (3) @(negedge clk);
    chk("rst_mid_dq", dq_pad, 16'h2222);
    rst_n = 0; tb_en = 1; #1;
    chk("rst_async_dq", dq_pad, PROBE);
    chk("rst_async_dqs", {dqs_pad, dqsbar_pad}, 4'b0110);
    chk("rst_async_st", {busy, cke_pad, cmd()}, 6'b001111);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("post_rst", {busy, rd_valid, cmd()}, 6'b001111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
